// File: rtl/lemming_pkg.sv
// Shared widths, action encoding and surface-map helpers for the lemming terrain model.
package lemming_pkg;

    localparam int FW      = 5;
    localparam int MAP_MAX = 256;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_FALL  = 3'd1,
        ACT_LAND  = 3'd2,
        ACT_DIG   = 3'd3,
        ACT_LEFT  = 3'd4,
        ACT_RIGHT = 3'd5
    } action_e;

    // Builds a packed map with every column set to the same surface row.
    function automatic logic [MAP_MAX-1:0] flat_map(input int cols, input int yw, input int val);
        logic [MAP_MAX-1:0] m;
        m = {MAP_MAX{1'b0}};
        for (int c = 0; c < cols; c++) begin
            m = m | (MAP_MAX'(val) << (c * yw));
        end
        return m;
    endfunction

    function automatic logic [7:0] surface_at(input logic [MAP_MAX-1:0] map, input int col,
                                              input int yw);
        logic [MAP_MAX-1:0] sh;
        sh = map >> (col * yw);
        return 8'(sh) & 8'((1 << yw) - 1);
    endfunction

endpackage

// File: rtl/lemming_fall_tracker.sv
// Saturating fall-length counter and the splat decision taken on landing.
module lemming_fall_tracker
    import lemming_pkg::*;
#(
    parameter int FALL_LIMIT = 5
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          fall_step,
    input  logic          land,
    output logic [FW-1:0] fall_cnt,
    output logic          land_splat
);

    logic [FW-1:0] fall_cnt_r;

    // Count cycles spent falling; a landing clears the count.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            fall_cnt_r <= {FW{1'b0}};
        end else if (land) begin
            fall_cnt_r <= {FW{1'b0}};
        end else if (fall_step && (fall_cnt_r != {FW{1'b1}})) begin
            fall_cnt_r <= fall_cnt_r + FW'(1);
        end else begin
            fall_cnt_r <= fall_cnt_r;
        end
    end

    assign fall_cnt   = fall_cnt_r;
    assign land_splat = (fall_cnt_r > FW'(FALL_LIMIT));

endmodule

// File: rtl/lemming_world.sv
// Closed-loop terrain model: tracks the lemming against a per-column surface map and feeds the walker FSM.
module lemming_world
    import lemming_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int DEPTH      = 8,
    parameter int X_INIT     = 4,
    parameter int Y_INIT     = 2,
    parameter int EXIT_COL   = 15,
    parameter int FALL_LIMIT = 5,
    parameter logic [MAP_MAX-1:0] INIT_SURFACE = flat_map(COLS, $clog2(DEPTH + 1), Y_INIT + 1)
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         walk_left,
    input  logic                         walk_right,
    input  logic                         aaah,
    input  logic                         digging,
    input  logic                         cfg_we,
    input  logic [$clog2(COLS)-1:0]      cfg_col,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_surf,
    output logic                         bump_left,
    output logic                         bump_right,
    output logic                         ground,
    output logic [$clog2(COLS)-1:0]      pos_x,
    output logic [$clog2(DEPTH+1)-1:0]   pos_y,
    output logic [FW-1:0]                fall_cnt,
    output logic                         splat,
    output logic                         saved,
    output logic                         lost,
    output logic                         done
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(DEPTH + 1);

    logic [YW-1:0] surf_r [COLS];
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          splat_r, saved_r, lost_r;
    logic          done_s, bump_left_s, bump_right_s, ground_s, land_splat_s, fall_step_s;
    action_e       action_s;

    assign done_s = splat_r | saved_r | lost_r;

    // Sensor decode from registered state only, so the Moore FSM loop stays acyclic.
    always_comb begin
        bump_left_s  = 1'b1;
        bump_right_s = 1'b1;
        if (x_r == {XW{1'b0}}) begin
            bump_left_s = 1'b1;
        end else begin
            bump_left_s = (surf_r[x_r - XW'(1)] <= y_r);
        end
        if (x_r == XW'(COLS - 1)) begin
            bump_right_s = 1'b1;
        end else begin
            bump_right_s = (surf_r[x_r + XW'(1)] <= y_r);
        end
        ground_s = (surf_r[x_r] == (y_r + YW'(1))) && (surf_r[x_r] != YW'(DEPTH));
    end

    // One action per edge, priority aaah > digging > walk_left > walk_right.
    always_comb begin
        action_s = ACT_NONE;
        if (done_s) begin
            action_s = ACT_NONE;
        end else if (aaah) begin
            action_s = ground_s ? ACT_LAND : ACT_FALL;
        end else if (digging) begin
            action_s = ground_s ? ACT_DIG : ACT_NONE;
        end else if (walk_left) begin
            action_s = bump_left_s ? ACT_NONE : ACT_LEFT;
        end else if (walk_right) begin
            action_s = bump_right_s ? ACT_NONE : ACT_RIGHT;
        end else begin
            action_s = ACT_NONE;
        end
    end

    assign fall_step_s = (action_s == ACT_FALL) && (y_r != YW'(DEPTH - 1));

    lemming_fall_tracker #(.FALL_LIMIT(FALL_LIMIT)) u_fall (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .fall_step  (fall_step_s),
        .land       (action_s == ACT_LAND),
        .fall_cnt   (fall_cnt),
        .land_splat (land_splat_s)
    );

    // Position, terrain and sticky status; cfg writes keep landing even after done.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            x_r     <= XW'(X_INIT);
            y_r     <= YW'(Y_INIT);
            splat_r <= 1'b0;
            saved_r <= 1'b0;
            lost_r  <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                surf_r[c] <= YW'(surface_at(INIT_SURFACE, c, YW));
            end
        end else begin
            case (action_s)
                ACT_FALL: begin
                    if (y_r == YW'(DEPTH - 1)) begin
                        lost_r <= 1'b1;
                    end else begin
                        y_r <= y_r + YW'(1);
                    end
                end
                ACT_LAND:  splat_r <= land_splat_s;
                ACT_DIG: begin
                    surf_r[x_r] <= surf_r[x_r] + YW'(1);
                    y_r         <= y_r + YW'(1);
                end
                ACT_LEFT:  x_r <= x_r - XW'(1);
                ACT_RIGHT: x_r <= x_r + XW'(1);
                default:   x_r <= x_r;
            endcase
            if (ground_s && (x_r == XW'(EXIT_COL)) && !done_s) begin
                saved_r <= 1'b1;
            end
            // The dig target is always column x, which a cfg write may never hit.
            if (cfg_we && (int'(cfg_col) < COLS) && (cfg_col != x_r)) begin
                surf_r[cfg_col] <= (cfg_surf > YW'(DEPTH)) ? YW'(DEPTH) : cfg_surf;
            end
        end
    end

    assign bump_left  = bump_left_s;
    assign bump_right = bump_right_s;
    assign ground     = ground_s;
    assign pos_x      = x_r;
    assign pos_y      = y_r;
    assign splat      = splat_r;
    assign saved      = saved_r;
    assign lost       = lost_r;
    assign done       = done_s;

endmodule

// File: tb/tb_lemming_world.sv
// Scoreboard bench for lemming_world, run in the DEPTH=16 configuration so a splat-length fall fits.
module tb_lemming_world;

    localparam int COLS = 16, DEPTH = 16, X_INIT = 4, Y_INIT = 2, EXIT_COL = 15, FALL_LIMIT = 5;

    logic       sys_clk = 1'b0, sys_rst_n = 1'b1;
    logic       walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_col = 4'd0;
    logic [4:0] cfg_surf = 5'd0;
    logic       bump_left, bump_right, ground, splat, saved, lost, done;
    logic [3:0] pos_x;
    logic [4:0] pos_y, fall_cnt;

    lemming_world #(.COLS(COLS), .DEPTH(DEPTH), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
                    .EXIT_COL(EXIT_COL), .FALL_LIMIT(FALL_LIMIT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .walk_left(walk_left), .walk_right(walk_right),
        .aaah(aaah), .digging(digging), .cfg_we(cfg_we), .cfg_col(cfg_col), .cfg_surf(cfg_surf),
        .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .pos_x(pos_x),
        .pos_y(pos_y), .fall_cnt(fall_cnt), .splat(splat), .saved(saved), .lost(lost), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int x, y, fall;
        bit splat, saved, lost, done, bl, br, g;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;

    // Reference world: plain integers driven by the textual rules.
    int mx, my, mfall;
    int msurf[COLS];
    bit msplat, msaved, mlost;

    function automatic bit m_ground();
        return (msurf[mx] == my + 1) && (msurf[mx] != DEPTH);
    endfunction
    function automatic bit m_bl();
        return (mx == 0) || (msurf[mx-1] <= my);
    endfunction
    function automatic bit m_br();
        return (mx == COLS - 1) || (msurf[mx+1] <= my);
    endfunction

    function automatic void m_reset();
        mx = X_INIT; my = Y_INIT; mfall = 0;
        msplat = 0; msaved = 0; mlost = 0;
        for (int c = 0; c < COLS; c++) msurf[c] = Y_INIT + 1;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.x = mx; e.y = my; e.fall = mfall;
        e.splat = msplat; e.saved = msaved; e.lost = mlost;
        e.done = msplat | msaved | mlost;
        e.bl = m_bl(); e.br = m_br(); e.g = m_ground();
        return e;
    endfunction

    function automatic void m_edge(bit wl, bit wr, bit aa, bit dg, bit we, int col, int sv);
        int ox = mx;
        bit g  = m_ground();
        bit bl = m_bl();
        bit br = m_br();
        if (!(msplat | msaved | mlost)) begin
            if (aa) begin
                if (!g) begin
                    if (my < DEPTH - 1) begin
                        my++;
                        if (mfall < 31) mfall++;
                    end else mlost = 1;
                end else begin
                    msplat = (mfall > FALL_LIMIT);
                    mfall  = 0;
                end
            end else if (dg) begin
                if (g) begin msurf[mx]++; my++; end
            end else if (wl) begin
                if (!bl) mx--;
            end else if (wr) begin
                if (!br) mx++;
            end
            if (g && ox == EXIT_COL) msaved = 1;
        end
        if (we && col < COLS && col != ox) msurf[col] = (sv > DEPTH) ? DEPTH : sv;
    endfunction

    function automatic void chk(string nm, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endfunction

    // Monitor: every edge that has an expectation queued is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pos_x", pos_x, e.x);       chk("pos_y", pos_y, e.y);
                chk("fall_cnt", fall_cnt, e.fall);
                chk("splat", splat, e.splat);   chk("saved", saved, e.saved);
                chk("lost", lost, e.lost);      chk("done", done, e.done);
                chk("bump_left", bump_left, e.bl);
                chk("bump_right", bump_right, e.br);
                chk("ground", ground, e.g);
            end
        end
    end

    // Called at a negedge: drive inputs, predict the next edge, wait for the following negedge.
    task automatic step(input bit wl, wr, aa, dg, input bit we = 1'b0, input int col = 0,
                        input int sv = 0);
        walk_left = wl; walk_right = wr; aaah = aa; digging = dg;
        cfg_we = we; cfg_col = 4'(col); cfg_surf = 5'(sv);
        m_edge(wl, wr, aa, dg, we, col, sv);
        exp_q.push_back(snap());
        @(negedge sys_clk);
    endtask

    task automatic reset_step();
        sys_rst_n = 1'b1;
        walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0; digging = 1'b0; cfg_we = 1'b0;
        m_reset();
        exp_q.push_back(snap());
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
    endtask

    initial begin
        @(negedge sys_clk);
        reset_step();
        // Walk left into the wall.
        repeat (5) step(1, 0, 0, 0);
        // Three-row drop then landing.
        reset_step();
        step(0, 0, 0, 0, 1, 5, 6);
        step(0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 0);
        // Dig twice in place.
        reset_step();
        repeat (2) step(0, 0, 0, 1);
        // Seven-row drop splats; walking afterwards is frozen.
        reset_step();
        step(0, 0, 0, 0, 1, 5, 10);
        step(0, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);
        // Bottomless pit: fall to the last row, then lost.
        reset_step();
        step(0, 0, 0, 0, 1, 5, 20);
        step(0, 1, 0, 0);
        repeat (15) step(0, 0, 1, 0);
        // cfg to the lemming's own column is ignored; col 9 becomes a wall.
        reset_step();
        step(0, 0, 0, 0, 1, 4, 1);
        step(0, 0, 0, 0, 1, 9, 1);
        repeat (5) step(0, 1, 0, 0);
        // Walk to the exit column.
        reset_step();
        step(0, 0, 0, 0, 1, 9, 3);
        repeat (13) step(0, 1, 0, 0);
        // Asynchronous reset in the middle of a fall.
        reset_step();
        step(0, 0, 0, 0, 1, 5, 12);
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        #2 sys_rst_n = 1'b1;
        #1;
        chk("async_rst_x", pos_x, X_INIT);
        chk("async_rst_y", pos_y, Y_INIT);
        chk("async_rst_fall", fall_cnt, 0);
        @(negedge sys_clk);
        reset_step();
        // Randomised episodes on random terrain.
        for (int ep = 0; ep < 8; ep++) begin
            reset_step();
            for (int k = 0; k < 5; k++)
                step(0, 0, 0, 0, 1, $urandom_range(0, COLS - 1), $urandom_range(0, 20));
            for (int k = 0; k < 80; k++)
                step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, COLS - 1),
                     $urandom_range(0, 20));
        end
        @(negedge sys_clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1);
    end

endmodule
